// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, IR, BYPASS, user DR, optional IDCODE.
// Define JTAG_TAP_IDCODE_EN to include the IDCODE data register.
module jtag_tap_ctrl #(
    parameter int                IR_W      = 4,
    parameter int                DR_W      = 32,
    parameter logic [31:0]       IDCODE    = 32'h1000_563D,
    parameter logic [IR_W-1:0]   IDCODE_OP = IR_W'(1),
    parameter logic [IR_W-1:0]   USER_OP   = IR_W'(2)
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            tms,
    input  logic            tdi,
    output logic            tdo,
    output logic            tdo_en,
    output logic [3:0]      state,
    output logic [IR_W-1:0] ir,
    input  logic [DR_W-1:0] dr_in,
    output logic [DR_W-1:0] dr_out,
    output logic            dr_update,
    output logic            dr_capture
);

    typedef enum logic [3:0] {
        S_EX2_DR = 4'h0, S_EX1_DR = 4'h1, S_SH_DR  = 4'h2, S_PS_DR  = 4'h3,
        S_SEL_IR = 4'h4, S_UPD_DR = 4'h5, S_CAP_DR = 4'h6, S_SEL_DR = 4'h7,
        S_EX2_IR = 4'h8, S_EX1_IR = 4'h9, S_SH_IR  = 4'hA, S_PS_IR  = 4'hB,
        S_RTI    = 4'hC, S_UPD_IR = 4'hD, S_CAP_IR = 4'hE, S_TLR    = 4'hF
    } tap_state_e;

    localparam logic [IR_W-1:0] IR_CAP = IR_W'(2'b01);
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_W-1:0] IR_RST = IDCODE_OP;
`else
    localparam logic [IR_W-1:0] IR_RST = '1;
`endif

    tap_state_e      state_q, state_d;
    logic [IR_W-1:0] ir_sr_q, ir_q;
    logic [DR_W-1:0] user_sr_q, dr_out_q;
    logic            bypass_q, dr_update_q;
    logic            sel_user, sel_idcode;
    logic [IR_W-1:0] ir_shift;
    logic [DR_W-1:0] user_shift;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_TLR:    state_d = tms ? S_TLR    : S_RTI;
            S_RTI:    state_d = tms ? S_SEL_DR : S_RTI;
            S_SEL_DR: state_d = tms ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: state_d = tms ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  state_d = tms ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: state_d = tms ? S_UPD_DR : S_PS_DR;
            S_PS_DR:  state_d = tms ? S_EX2_DR : S_PS_DR;
            S_EX2_DR: state_d = tms ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: state_d = tms ? S_SEL_DR : S_RTI;
            S_SEL_IR: state_d = tms ? S_TLR    : S_CAP_IR;
            S_CAP_IR: state_d = tms ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  state_d = tms ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: state_d = tms ? S_UPD_IR : S_PS_IR;
            S_PS_IR:  state_d = tms ? S_EX2_IR : S_PS_IR;
            S_EX2_IR: state_d = tms ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: state_d = tms ? S_SEL_DR : S_RTI;
            default:  state_d = S_TLR;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= S_TLR;
        else          state_q <= state_d;
    end

    // All-ones is BYPASS even if USER_OP were configured to it.
    assign sel_user = (ir_q == USER_OP) && (ir_q != '1);

    // Right shift with tdi entering the MSB; width-agnostic so 1-bit DRs work.
    assign ir_shift   = IR_W'({tdi, ir_sr_q} >> 1);
    assign user_shift = DR_W'({tdi, user_sr_q} >> 1);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ir_sr_q <= '0;
            ir_q    <= IR_RST;
        end else begin
            if (state_q == S_CAP_IR)     ir_sr_q <= IR_CAP;
            else if (state_q == S_SH_IR) ir_sr_q <= ir_shift;
            if (state_q == S_TLR)         ir_q <= IR_RST;
            else if (state_q == S_UPD_IR) ir_q <= ir_sr_q;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bypass_q    <= 1'b0;
            user_sr_q   <= '0;
            dr_out_q    <= '0;
            dr_update_q <= 1'b0;
        end else begin
            dr_update_q <= (state_q == S_UPD_DR) && sel_user;
            if (state_q == S_CAP_DR) begin
                bypass_q <= 1'b0;
                if (sel_user) user_sr_q <= dr_in;
            end else if (state_q == S_SH_DR) begin
                if (sel_user)                    user_sr_q <= user_shift;
                else if (!sel_idcode)            bypass_q  <= tdi;
            end
            if ((state_q == S_UPD_DR) && sel_user) dr_out_q <= user_sr_q;
        end
    end

`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0] id_sr_q;

    assign sel_idcode = (ir_q == IDCODE_OP) && !sel_user;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                                id_sr_q <= '0;
        else if (state_q == S_CAP_DR)                id_sr_q <= IDCODE;
        else if ((state_q == S_SH_DR) && sel_idcode) id_sr_q <= {tdi, id_sr_q[31:1]};
    end

    always_comb begin
        tdo = 1'b0;
        if (state_q == S_SH_IR)      tdo = ir_sr_q[0];
        else if (state_q == S_SH_DR) tdo = sel_user ? user_sr_q[0] :
                                           sel_idcode ? id_sr_q[0] : bypass_q;
    end
`else
    logic unused_idcode;
    assign unused_idcode = ^{IDCODE, IDCODE_OP};
    assign sel_idcode    = 1'b0;

    always_comb begin
        tdo = 1'b0;
        if (state_q == S_SH_IR)      tdo = ir_sr_q[0];
        else if (state_q == S_SH_DR) tdo = sel_user ? user_sr_q[0] : bypass_q;
    end
`endif

    assign tdo_en     = (state_q == S_SH_DR) || (state_q == S_SH_IR);
    assign state      = state_q;
    assign ir         = ir_q;
    assign dr_out     = dr_out_q;
    assign dr_update  = dr_update_q;
    assign dr_capture = (state_q == S_CAP_DR) && sel_user;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: FSM arcs, TLR recovery, IR/BYPASS/IDCODE/user DR, pause, reset.
module tb_jtag_tap_ctrl;
    localparam int            IR_W      = 4;
    localparam int            DR_W      = 32;
    localparam logic [3:0]    IDCODE_OP = 4'h1;
    localparam logic [3:0]    USER_OP   = 4'h2;
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [3:0]    RST_IR    = IDCODE_OP;
`else
    localparam logic [3:0]    RST_IR    = 4'hF;
`endif

    logic            CLK, RESET_N, tms, tdi, tdo, tdo_en, dr_update, dr_capture;
    logic [3:0]      state;
    logic [IR_W-1:0] ir;
    logic [DR_W-1:0] dr_in, dr_out;

    int n_checks = 0;
    int n_err    = 0;

    jtag_tap_ctrl #(.IR_W(IR_W), .DR_W(DR_W), .IDCODE(32'h1000_563D),
                    .IDCODE_OP(IDCODE_OP), .USER_OP(USER_OP)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
        .state(state), .ir(ir), .dr_in(dr_in), .dr_out(dr_out),
        .dr_update(dr_update), .dr_capture(dr_capture));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Every arc of the TAP graph once, starting in TLR.
    bit         walk_tms [44] = '{1,0,0,1,0,0,0,1,0,0,1,0,1,1,1,0,1,0,1,1,0,1,
                                   1,0,0,0,1,0,0,1,0,1,1,1,1,0,1,0,1,1,0,1,1,1};
    logic [3:0] walk_st  [44] = '{4'hF,4'hC,4'hC,4'h7,4'h6,4'h2,4'h2,4'h1,4'h3,4'h3,4'h0,
                                   4'h2,4'h1,4'h5,4'h7,4'h6,4'h1,4'h3,4'h0,4'h5,4'hC,4'h7,
                                   4'h4,4'hE,4'hA,4'hA,4'h9,4'hB,4'hB,4'h8,4'hA,4'h9,4'hD,
                                   4'h7,4'h4,4'hE,4'h9,4'hB,4'h8,4'hD,4'hC,4'h7,4'h4,4'hF};
    // Path from TLR to each state, tms applied LSB first.
    int         plen  [16] = '{0,1,2,3,4,4,5,6,5,3,4,5,5,6,7,6};
    logic [6:0] pbits [16] = '{7'b0000000,7'b0000000,7'b0000010,7'b0000010,7'b0000010,
                               7'b0001010,7'b0001010,7'b0101010,7'b0011010,7'b0000110,
                               7'b0000110,7'b0000110,7'b0010110,7'b0010110,7'b1010110,
                               7'b0110110};
    logic [3:0] ptgt  [16] = '{4'hF,4'hC,4'h7,4'h6,4'h2,4'h1,4'h3,4'h0,4'h5,4'h4,
                               4'hE,4'hA,4'h9,4'hB,4'h8,4'hD};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge CLK);
        #1;
    endtask

    // From RTI: load IR with val, ending back in RTI.
    task automatic load_ir(input logic [3:0] val);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        check("ir_tdo_en", tdo_en, 1'b1);
        for (int i = 0; i < IR_W; i++) begin
            check($sformatf("ir_cap_tdo%0d", i), tdo, (i == 0) ? 1'b1 : 1'b0);
            step(i == IR_W - 1, val[i]);
        end
        step(1, 0); step(0, 0);
        check("ir_loaded", ir, val);
    endtask

    // From RTI: one BYPASS DR scan, ending in RTI.
    task automatic bypass_probe(input string tag);
        step(1, 0); step(0, 0); step(0, 0);
        check({tag, "_cap0"}, tdo, 1'b0);
        step(0, 1);
        check({tag, "_sh1"}, tdo, 1'b1);
        step(0, 0);
        check({tag, "_sh0"}, tdo, 1'b0);
        step(1, 0);
        check({tag, "_ex1_en"}, tdo_en, 1'b0);
        check({tag, "_ex1_tdo"}, tdo, 1'b0);
        step(1, 0); step(0, 0);
        check({tag, "_no_upd"}, dr_update, 1'b0);
    endtask

    initial begin
        logic [31:0] idv, cap_v, sh_v, pv;
        idv = 32'h1000_563D;
        RESET_N = 1'b0; tms = 1'b1; tdi = 1'b0; dr_in = '0;
        #12;
        check("rst_state", state, 4'hF);
        check("rst_ir", ir, RST_IR);
        check("rst_dr_out", dr_out, 32'h0);
        check("rst_upd", dr_update, 1'b0);
        check("rst_cap", dr_capture, 1'b0);
        check("rst_tdo_en", tdo_en, 1'b0);
        check("rst_tdo", tdo, 1'b0);
        RESET_N = 1'b1;

        for (int i = 0; i < 44; i++) begin
            step(walk_tms[i], 0);
            check($sformatf("walk%0d", i), state, walk_st[i]);
        end

        for (int s = 0; s < 16; s++) begin
            for (int j = 0; j < plen[s]; j++) step(pbits[s][j], 0);
            check($sformatf("path%0d", s), state, ptgt[s]);
            for (int j = 0; j < 5; j++) step(1, 0);
            check($sformatf("tlr_from%0d", s), state, 4'hF);
        end
        check("tlr_ir", ir, RST_IR);

`ifdef JTAG_TAP_IDCODE_EN
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        check("id_state", state, 4'h2);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("idcode_b%0d", i), tdo, idv[i]);
            step(i == 31, 0);
        end
        step(1, 0); step(0, 0);
`else
        step(0, 0);
        load_ir(IDCODE_OP);
        bypass_probe("idop_byp");
`endif

        load_ir(4'hF);
        bypass_probe("byp");

        // User DR capture/shift/update, dr_in changed after capture.
        load_ir(USER_OP);
        cap_v = 32'hA5A5_0F0F; sh_v = 32'hDEAD_BEEF;
        dr_in = cap_v;
        step(1, 0);
        check("cap_pre", dr_capture, 1'b0);
        step(0, 0);
        check("cap_pulse", dr_capture, 1'b1);
        step(0, 0);
        check("cap_post", dr_capture, 1'b0);
        dr_in = 32'h1234_5678;
        for (int i = 0; i < 32; i++) begin
            check($sformatf("user_tdo%0d", i), tdo, cap_v[i]);
            step(i == 31, sh_v[i]);
        end
        check("dr_out_hold_ex1", dr_out, 32'h0);
        step(1, 0);
        check("upd_pre", dr_update, 1'b0);
        check("dr_out_hold_upd", dr_out, 32'h0);
        step(0, 0);
        check("upd_pulse", dr_update, 1'b1);
        check("dr_out_new", dr_out, sh_v);
        step(0, 0);
        check("upd_post", dr_update, 1'b0);
        check("dr_out_keep", dr_out, sh_v);

        // Pause in the middle of a user DR shift.
        cap_v = 32'h1357_9BDF; pv = 32'hC3A5_9617;
        dr_in = cap_v;
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("p1_tdo%0d", i), tdo, cap_v[i]);
            step(i == 9, pv[i]);
        end
        for (int i = 0; i < 5; i++) step(0, 1);
        check("pause_state", state, 4'h3);
        check("pause_tdo_en", tdo_en, 1'b0);
        step(1, 0);
        check("ex2_state", state, 4'h0);
        step(0, 0);
        for (int i = 10; i < 32; i++) begin
            check($sformatf("p2_tdo%0d", i), tdo, cap_v[i]);
            step(i == 31, pv[i]);
        end
        step(1, 0); step(0, 0);
        check("pause_dr_out", dr_out, pv);

        // TLR via tms resets ir but not dr_out.
        for (int i = 0; i < 5; i++) step(1, 0);
        check("tlr2_state", state, 4'hF);
        check("tlr2_ir", ir, RST_IR);
        check("tlr2_dr_out", dr_out, pv);
        step(0, 0);

        // Asynchronous reset in the middle of a shift.
        load_ir(USER_OP);
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 5; i++) step(0, 1);
        RESET_N = 1'b0;
        #1;
        check("mid_rst_state", state, 4'hF);
        check("mid_rst_dr_out", dr_out, 32'h0);
        check("mid_rst_tdo_en", tdo_en, 1'b0);
        check("mid_rst_ir", ir, RST_IR);
        #1;
        RESET_N = 1'b1;
        step(0, 0);
        check("post_rst_rti", state, 4'hC);
        load_ir(USER_OP);
        check("post_rst_dr_out", dr_out, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #90000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

Parametrised JTAG test-access-port controller: the 16-state TAP state machine plus instruction register, BYPASS, optional IDCODE and one user data register of configurable width. Sits between the board-level JTAG pins, already synchronised to the single design clock `CLK` (one `CLK` rising edge per TCK rising edge), and on-chip debug/config logic, which it serves through a capture/update parallel port.

## Interface
- `IR_W`, 4: instruction register width, ≥ 2.
- `DR_W`, 32: user data register width, ≥ 1.
- `IDCODE`, 32'h1000_563D: IDCODE value; bit 0 must be 1.
- `IDCODE_OP`, 1: IDCODE opcode (IR_W bits).
- `USER_OP`, 2: user DR opcode (IR_W bits); all-ones is always BYPASS.

- `CLK` in 1: clock; all state changes on rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `tms` in 1: test mode select.
- `tdi` in 1: serial data in.
- `tdo` out 1: serial data out, LSB of the selected shift register.
- `tdo_en` out 1: high in Shift-DR or Shift-IR.
- `state` out 4: current TAP state.
- `ir` out IR_W: active instruction.
- `dr_in` in DR_W: parallel value captured into the user DR.
- `dr_out` out DR_W: last updated user DR value.
- `dr_update` out 1: one-cycle pulse when `dr_out` is loaded.
- `dr_capture` out 1: one-cycle pulse on the cycle `dr_in` is sampled.

## Operation
- State encoding (IEEE 1149.1): TLR 15, RTI 12, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR 14, ShIR 10, Ex1IR 9, PauseIR 11, Ex2IR 8, UpdIR 13.
- Transitions (tms=0 / tms=1): TLR→RTI/TLR; RTI→RTI/SelDR; SelDR→CapDR/SelIR; SelIR→CapIR/TLR; CapX→ShX/Ex1X; ShX→ShX/Ex1X; Ex1X→PauseX/UpdX; PauseX→PauseX/Ex2X; Ex2X→ShX/UpdX; UpdX→RTI/SelDR.
- Five consecutive tms=1 cycles reach TLR from any state.
- DR select by `ir`: IDCODE_OP → IDCODE register, USER_OP → user DR, anything else (incl. all-ones) → 1-bit BYPASS.
- Edge in CapIR: IR shift register ← {0…0,01}.
- Edge in CapDR: BYPASS ← 0; IDCODE reg ← `IDCODE`; user DR ← `dr_in`.
- Edge in ShX (including the exiting edge): selected register shifts right, `tdi` into MSB; unselected registers hold.
- Edge in UpdIR: `ir` ← IR shift register. Edge in UpdDR with USER_OP: `dr_out` ← user DR shift register.
- TLR (state, not just reset): `ir` ← IDCODE_OP; shift registers untouched; `dr_out` holds.
- Pause states hold all shift registers.

## Timing
- Reset (`RESET_N`=0, immediate): `state`=15, `ir`=IDCODE_OP, `dr_out`=0, shift registers 0, `dr_update`=0, `dr_capture`=0, `tdo_en`=0.
- Reset mid-shift discards the partial shift; `dr_out` returns to 0.
- `tdo`, `tdo_en` derive combinationally from registered state/shift registers only; no `tdi`→`tdo` combinational path. `tdo`=0 when `tdo_en`=0.
- `dr_capture` high for exactly the cycle `state`=CapDR with USER_OP; `dr_in` sampled at the end of that cycle.
- `dr_update` high for exactly the cycle after the UpdDR edge (with USER_OP), aligned with the new `dr_out`.
- Shift latency: N-bit register fully replaced after N edges in ShX; bit k of the old value appears on `tdo` after k edges.
- `ir` change takes effect for the DR select from the cycle after UpdIR.

## Configuration
- `JTAG_TAP_IDCODE_EN` defined: IDCODE register present; reset/TLR `ir`=IDCODE_OP; IDCODE_OP selects it.
- Undefined: no IDCODE register; reset/TLR `ir`=all-ones (BYPASS); IDCODE_OP decodes to BYPASS.

## Test plan
- Reset, then tms=1×5 from each of the 16 states → `state`=15 each time; walk every arc once, checking `state`.
- Macro on: reset, tms 0,1,0,0 to ShDR, 32 shifts tdi=0 → `tdo` sequence equals `IDCODE` LSB-first (0x1000_563D).
- Load IR: shift 4'b1111 via ShIR, exit through UpdIR → `ir`=4'hF; CapDR then one ShDR edge → `tdo`=0; next edge `tdo` = prior `tdi`.
- Load USER_OP, `dr_in`=32'hA5A5_0F0F: CapDR → `dr_capture` 1 cycle; shift in 32'hDEAD_BEEF while reading `tdo`=A5A5_0F0F LSB-first; UpdDR → `dr_out`=DEAD_BEEF, `dr_update` 1 cycle.
- Pause mid-shift: 10 shifts, PauseDR 5 cycles, Ex2DR→ShDR, 22 shifts → `dr_out` equals full 32-bit value shifted in.
- Assert `RESET_N` during ShDR → `state`=15, `dr_out`=0, `tdo_en`=0 immediately; macro off, CapIR→ShIR shows `tdo` 1 then 0.
